// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory-controller port among IF, LSB and PF,
// with IO-store gating on a full UART buffer and flush handling that drains in-flight reads.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              clr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_ls_type,
  input  logic [DATA_W-1:0] lsb_st_val,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_data,
  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              pf_done,
  output logic [DATA_W-1:0] pf_data,
  output logic              mc_enable,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_ls_type,
  output logic [DATA_W-1:0] mc_st_val,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_ld_val,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, GAP} state_t;
  state_t state;
  logic [1:0] rr_last, gnt, c0, c1, pick;
  logic [2:0] elig;
  logic kill;
  assign busy = state != IDLE;
  // Committed stores stay eligible through a flush; only IO stores wait on the UART buffer.
  always_comb begin
    elig = {pf_req && !clr,
            lsb_req && (lsb_wr ? !(lsb_addr[17:16] == IO_HI && io_buffer_full) : !clr),
            if_req && !clr};
    c0 = rr_last == 2'd2 ? 2'd0 : rr_last + 2'd1;
    c1 = c0 == 2'd2 ? 2'd0 : c0 + 2'd1;
    pick = elig[c0] ? c0 : elig[c1] ? c1 : rr_last;
    kill = clr && !mc_wr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_last <= 2'd2;
      gnt <= 2'd0;
      mc_enable <= 1'b0;
      mc_wr <= 1'b0;
      mc_addr <= '0;
      mc_ls_type <= '0;
      mc_st_val <= '0;
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      pf_done <= 1'b0;
      if_data <= '0;
      lsb_data <= '0;
      pf_data <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      pf_done <= 1'b0;
      if_data <= '0;
      lsb_data <= '0;
      pf_data <= '0;
      case (state)
        IDLE: if (|elig) begin
          state <= BUSY;
          gnt <= pick;
          rr_last <= pick;
          mc_enable <= 1'b1;
          mc_wr <= pick == 2'd1 && lsb_wr;
          mc_addr <= pick == 2'd0 ? if_addr : pick == 2'd1 ? lsb_addr : pf_addr;
          mc_ls_type <= pick == 2'd1 ? lsb_ls_type : 3'b111;
          mc_st_val <= pick == 2'd1 ? lsb_st_val : '0;
        end
        // A flushed read keeps the controller request up until it answers, then drops the result.
        BUSY: if (mc_done || kill) begin
          state <= mc_done ? GAP : DRAIN;
          mc_enable <= !mc_done;
          if (mc_done && !kill) begin
            if_done <= gnt == 2'd0;
            lsb_done <= gnt == 2'd1;
            pf_done <= gnt == 2'd2;
            if_data <= gnt == 2'd0 ? mc_ld_val : '0;
            lsb_data <= gnt == 2'd1 && !mc_wr ? mc_ld_val : '0;
            pf_data <= gnt == 2'd2 ? mc_ld_val : '0;
          end
        end
        DRAIN: if (mc_done) begin
          state <= GAP;
          mc_enable <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
